// File: rtl/ternary_decompress.sv
// Streaming decompressor: 32-bit words of base-3 packed bytes (5 trits/byte) to fixed-size beats of 2-bit signed trits.
// Byte code = sum_i (t_i + 1) * 3^i, i = 0..4, so trit 0 is the least-significant base-3 digit.
module ternary_decompress #(
    parameter int INPUT_WIDTH = 32,
    parameter int OUT_TRITS   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic [INPUT_WIDTH-1:0] data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [2*OUT_TRITS-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o
);

    localparam int N_BYTES   = INPUT_WIDTH / 8;
    localparam int N_TRITS   = 5 * N_BYTES;
    localparam int BEATS     = N_TRITS / OUT_TRITS;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BITS = 2 * OUT_TRITS;

    generate
        if ((INPUT_WIDTH % 8 != 0) || (N_TRITS % OUT_TRITS != 0)) begin : g_bad_params
            $error("ternary_decompress: INPUT_WIDTH must be a multiple of 8 and N_TRITS a multiple of OUT_TRITS");
        end
    endgenerate

    typedef enum logic {
        EMPTY,
        DRAIN
    } state_t;

    state_t                 r_state;
    logic [BEAT_W-1:0]      r_beat;
    logic [2*N_TRITS-1:0]   r_trits;

    logic [2*N_TRITS-1:0]   w_decoded;
    logic [BEAT_BITS-1:0]   w_slice;
    logic                   w_valid;
    logic                   w_last;
    logic                   w_load;

    // Codes 243..255 fall out of the same digit extraction, so they decode deterministically.
    function automatic logic [9:0] decodeByte(input logic [7:0] code);
        logic [7:0] rem;
        logic [1:0] digit;
        logic [9:0] trits;
        rem   = code;
        trits = '0;
        for (int i = 0; i < 5; i++) begin
            digit = 2'(rem % 8'd3);
            rem   = rem / 8'd3;
            case (digit)
                2'd0:    trits[2*i +: 2] = 2'b11;
                2'd2:    trits[2*i +: 2] = 2'b01;
                default: trits[2*i +: 2] = 2'b00;
            endcase
        end
        return trits;
    endfunction

    always_comb begin
        w_decoded = '0;
        for (int b = 0; b < N_BYTES; b++) begin
            w_decoded[10*b +: 10] = decodeByte(data_i[8*b +: 8]);
        end
    end

    assign w_valid = (r_state == DRAIN);
    assign w_last  = w_valid && (r_beat == BEAT_W'(BEATS - 1));
    assign w_slice = r_trits[r_beat*BEAT_BITS +: BEAT_BITS];

    assign valid_o = w_valid;
    assign last_o  = w_last;
    assign data_o  = w_valid ? w_slice : '0;
    assign ready_o = !clear_i && ((r_state == EMPTY) || (ready_i && w_last));
    assign w_load  = valid_i && ready_o;

    // Clear beats a load, and a load beats retiring the last beat so words chain without a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
            r_beat  <= '0;
            r_trits <= '0;
        end else if (clear_i) begin
            r_state <= EMPTY;
            r_beat  <= '0;
        end else if (w_load) begin
            r_trits <= w_decoded;
            r_beat  <= '0;
            r_state <= DRAIN;
        end else if (w_valid && ready_i) begin
            if (w_last) begin
                r_state <= EMPTY;
                r_beat  <= '0;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ternary_decompress.sv
// Randomized self-checking bench for ternary_decompress with a trit-level reference model.
module tb_ternary_decompress;

    localparam int INPUT_WIDTH = 32;
    localparam int OUT_TRITS   = 4;
    localparam int N_TRITS     = 20;
    localparam int BEATS       = 5;

    typedef int         tritWord_t [N_TRITS];
    typedef logic [7:0] beats_t    [BEATS];

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   clear_i;
    logic [INPUT_WIDTH-1:0] data_i;
    logic                   valid_i;
    logic                   ready_o;
    logic [2*OUT_TRITS-1:0] data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   last_o;

    int         checks   = 0;
    int         failures = 0;
    tritWord_t  curTrits;
    logic [8:0] expQ[$];
    logic [8:0] expBeat;
    logic       prevStall = 1'b0;
    logic [8:0] prevOut   = '0;

    ternary_decompress #(.INPUT_WIDTH(INPUT_WIDTH), .OUT_TRITS(OUT_TRITS)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] encodeWord(input tritWord_t t);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < INPUT_WIDTH / 8; b++) begin
            int v;
            int p;
            v = 0;
            p = 1;
            for (int i = 0; i < 5; i++) begin
                v += (t[5*b + i] + 1) * p;
                p *= 3;
            end
            w[8*b +: 8] = 8'(v);
        end
        return w;
    endfunction

    function automatic logic [7:0] beatOf(input tritWord_t t, input int b);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < OUT_TRITS; j++) begin
            case (t[b*OUT_TRITS + j])
                -1:      r[2*j +: 2] = 2'b11;
                1:       r[2*j +: 2] = 2'b01;
                default: r[2*j +: 2] = 2'b00;
            endcase
        end
        return r;
    endfunction

    task automatic randWord(output tritWord_t t);
        for (int k = 0; k < N_TRITS; k++) t[k] = int'($urandom_range(2)) - 1;
    endtask

    task automatic constWord(input int v, output tritWord_t t);
        for (int k = 0; k < N_TRITS; k++) t[k] = v;
    endtask

    task automatic applyStimulus(input tritWord_t t, input logic valid);
        curTrits = t;
        data_i   = encodeWord(t);
        valid_i  = valid;
    endtask

    // Sends one word into an idle DUT with ready_i high and checks its five consecutive beats.
    task automatic runWordExpect(input tritWord_t t, input beats_t exp, input string tag);
        applyStimulus(t, 1'b1);
        @(negedge clk_i);
        checkOutput({tag, "_accept_ready"}, ready_o, 1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk_i);
            checkOutput({tag, "_valid"}, valid_o, 1);
            checkOutput({tag, "_data"}, data_o, exp[b]);
            checkOutput({tag, "_last"}, last_o, (b == BEATS - 1));
        end
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: every accepted word queues its beats; every consumed beat is popped and compared.
    always @(negedge clk_i) begin
        if (rst_i || clear_i) begin
            expQ.delete();
            prevStall = 1'b0;
        end else begin
            if (!valid_o) begin
                checkOutput("idle_zero", {last_o, data_o}, 0);
                checkOutput("ready_idle", ready_o, 1);
            end else begin
                checkOutput("ready_on_last", ready_o, ready_i && last_o);
            end
            if (valid_o && prevStall) checkOutput("stall_hold", {last_o, data_o}, prevOut);
            if (valid_o && ready_i) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_beat", valid_o, 0);
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("beat", {last_o, data_o}, expBeat);
                end
            end
            prevStall = valid_o && !ready_i;
            prevOut   = {last_o, data_o};
            if (valid_i && ready_o) begin
                for (int b = 0; b < BEATS; b++) expQ.push_back({(b == BEATS - 1), beatOf(curTrits, b)});
            end
        end
    end

    initial begin
        tritWord_t w;
        tritWord_t words[4];
        beats_t    exp;
        int        idx;
        logic      hs;

        rst_i   = 1'b1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        for (int k = 0; k < N_TRITS; k++) curTrits[k] = 0;

        #1;
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_data", data_o, 0);
        checkOutput("rst_last", last_o, 0);
        checkOutput("rst_ready", ready_o, 1);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        for (int k = 0; k < N_TRITS; k++) w[k] = (k % 3) - 1;
        runWordExpect(w, '{8'hD3, 8'h34, 8'h4D, 8'hD3, 8'h34}, "pattern");

        constWord(0, w);
        runWordExpect(w, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, "zeros");
        constWord(1, w);
        runWordExpect(w, '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55}, "plus");
        constWord(-1, w);
        runWordExpect(w, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, "minus");

        for (int n = 0; n < 3; n++) begin
            randWord(w);
            words[n] = w;
        end
        idx = 0;
        applyStimulus(words[0], 1'b1);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            if (c > 0) checkOutput("b2b_valid", valid_o, 1);
            hs = valid_i && ready_o;
            @(posedge clk_i);
            #1;
            if (hs) begin
                idx++;
                if (idx < 3) applyStimulus(words[idx], 1'b1);
                else valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        checkOutput("b2b_done", valid_o, 0);
        checkOutput("b2b_accepted", idx, 3);
        @(posedge clk_i);
        #1;

        for (int n = 0; n < 4; n++) begin
            randWord(w);
            words[n] = w;
        end
        idx = 0;
        applyStimulus(words[0], ($urandom_range(3) != 0));
        ready_i = ($urandom_range(2) != 0);
        for (int c = 0; c < 150; c++) begin
            @(negedge clk_i);
            hs = valid_i && ready_o;
            @(posedge clk_i);
            #1;
            if (hs) idx++;
            if (idx < 4) applyStimulus(words[idx], ($urandom_range(3) != 0));
            else valid_i = 1'b0;
            ready_i = ($urandom_range(2) != 0);
        end
        ready_i = 1'b1;
        for (int c = 0; c < 20 && (valid_o || expQ.size() != 0); c++) @(posedge clk_i);
        #1;
        checkOutput("bp_accepted", idx, 4);
        checkOutput("bp_drained", expQ.size(), 0);
        checkOutput("bp_idle", valid_o, 0);

        randWord(w);
        applyStimulus(w, 1'b1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        randWord(w);
        applyStimulus(w, 1'b1);
        clear_i = 1'b1;
        @(negedge clk_i);
        checkOutput("clr_ready", ready_o, 0);
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("clr_valid", valid_o, 0);
        checkOutput("clr_data", data_o, 0);
        @(posedge clk_i);
        #1;
        for (int b = 0; b < BEATS; b++) exp[b] = beatOf(w, b);
        runWordExpect(w, exp, "after_clr");

        constWord(1, w);
        applyStimulus(w, 1'b1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        checkOutput("midrst_valid", valid_o, 0);
        checkOutput("midrst_data", data_o, 0);
        checkOutput("midrst_last", last_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("post_rst_ready", ready_o, 1);
        checkOutput("post_rst_valid", valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
